// File: rtl/dmem_arbiter_if.sv
// Request/response and DMEM signal bundle around dmem_arbiter.
// master = the arbiter itself, slave = the pipeline stages and DMEM around it.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic              lsu_we;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [7:0]        lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_r_EN;
  logic              mem_w_EN;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    input  mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_r_EN, mem_w_EN, mem_addr, mem_wdata, mem_wmask
  );

  modport slave (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    output mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_r_EN, mem_w_EN, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one DMEM port between IFU (read) and LSU (read/write); accept at t, enables t+1..t+MEM_LAT,
// one-cycle response at t+MEM_LAT+1; requesters wait on ready, responses have no backpressure.
module dmem_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MEM_LAT  = 2,
  parameter int LSU_PRIO = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.master bus
);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [7:0]        wmask_q;
  logic              we_q;
  logic              own_lsu_q;
  logic              last_lsu_q;
  logic              grant_ifu;
  logic              grant_lsu;
  logic              in_access;
  logic              in_resp;

  // Grant doubles as ready: it already implies the matching valid.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (rst_n && state_q == IDLE) begin
      if (LSU_PRIO != 0) begin
        grant_lsu = bus.lsu_req_valid;
        grant_ifu = bus.ifu_req_valid && !bus.lsu_req_valid;
      end else if (bus.ifu_req_valid && bus.lsu_req_valid) begin
        grant_lsu = !last_lsu_q;
        grant_ifu = last_lsu_q;
      end else begin
        grant_lsu = bus.lsu_req_valid;
        grant_ifu = bus.ifu_req_valid;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_ifu || grant_lsu) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      we_q       <= 1'b0;
      own_lsu_q  <= 1'b0;
      last_lsu_q <= 1'b1;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant_lsu) begin
        addr_q     <= bus.lsu_addr;
        wdata_q    <= bus.lsu_wdata;
        wmask_q    <= bus.lsu_wmask;
        we_q       <= bus.lsu_we;
        own_lsu_q  <= 1'b1;
        last_lsu_q <= 1'b1;
      end else if (grant_ifu) begin
        addr_q     <= bus.ifu_addr;
        wdata_q    <= '0;
        wmask_q    <= '0;
        we_q       <= 1'b0;
        own_lsu_q  <= 1'b0;
        last_lsu_q <= 1'b0;
      end
      if (state_q == ACCESS && cnt_q == '0) begin
        rdata_q <= we_q ? '0 : bus.mem_rdata;
      end
    end
  end

  // Outputs are forced quiet while rst_n is low, so an abandoned access never leaks out.
  assign in_access = rst_n && (state_q == ACCESS);
  assign in_resp   = rst_n && (state_q == RESP);

  assign bus.ifu_req_ready  = grant_ifu;
  assign bus.lsu_req_ready  = grant_lsu;
  assign bus.ifu_resp_valid = in_resp && !own_lsu_q;
  assign bus.lsu_resp_valid = in_resp && own_lsu_q;
  assign bus.ifu_rdata      = rst_n ? rdata_q : '0;
  assign bus.lsu_rdata      = rst_n ? rdata_q : '0;

  assign bus.mem_r_EN  = in_access && !we_q;
  assign bus.mem_w_EN  = in_access && we_q;
  assign bus.mem_addr  = in_access ? addr_q  : '0;
  assign bus.mem_wdata = in_access ? wdata_q : '0;
  assign bus.mem_wmask = in_access ? wmask_q : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Three arbiter configurations (LAT2/LSU-prio, LAT2/round-robin, LAT1/round-robin) driven side by side,
// each checked every cycle against a transaction-level model of accept/access/response timing.
module tb_dmem_arbiter;
  typedef struct packed {
    logic        ifu_v;
    logic [63:0] ifu_addr;
    logic        lsu_v;
    logic        lsu_we;
    logic [63:0] lsu_addr;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
  } in_t;

  typedef struct packed {
    logic        ifu_rdy;
    logic        lsu_rdy;
    logic        ifu_rv;
    logic        lsu_rv;
    logic [63:0] ifu_rdata;
    logic [63:0] lsu_rdata;
    logic        r_en;
    logic        w_en;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  in_t  stim [3];
  out_t obs  [3];
  out_t snap [3];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  function automatic logic [63:0] memf(logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h0000_0413_0000_0093;
    return {a[31:0] ^ 32'hA5A5_0F0F, ~a[31:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();
    dmem_arbiter #(
      .ADDR_W(64), .DATA_W(64),
      .MEM_LAT((g == 2) ? 1 : 2),
      .LSU_PRIO((g == 0) ? 1 : 0)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
    );
    assign bus.ifu_req_valid = stim[g].ifu_v;
    assign bus.ifu_addr      = stim[g].ifu_addr;
    assign bus.lsu_req_valid = stim[g].lsu_v;
    assign bus.lsu_we        = stim[g].lsu_we;
    assign bus.lsu_addr      = stim[g].lsu_addr;
    assign bus.lsu_wdata     = stim[g].lsu_wdata;
    assign bus.lsu_wmask     = stim[g].lsu_wmask;
    assign bus.mem_rdata     = memf(bus.mem_addr);
    assign obs[g] = {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid,
                     bus.ifu_rdata, bus.lsu_rdata, bus.mem_r_EN, bus.mem_w_EN,
                     bus.mem_addr, bus.mem_wdata, bus.mem_wmask};
  end

  // Model: one outstanding transaction per instance, timed by its accept cycle.
  int          lat_of  [3] = '{2, 2, 1};
  bit          prio_of [3] = '{1'b1, 1'b0, 1'b0};
  bit          m_busy  [3];
  int          m_acc   [3];
  bit          m_lsu   [3];
  bit          m_last  [3];
  bit          m_we    [3];
  logic [63:0] m_addr  [3];
  logic [63:0] m_wdata [3];
  logic [7:0]  m_mask  [3];
  logic [63:0] m_rd    [3];

  task automatic chk1(string nm, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc %0d: got %b, want %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk64(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    for (int g = 0; g < 3; g++) begin
      out_t e;
      int   ph;
      bit   any, pick_lsu;
      e = '0;
      if (!rst_n) begin
        m_busy[g] = 1'b0;
        m_last[g] = 1'b1;
        m_rd[g]   = '0;
      end else begin
        e.ifu_rdata = m_rd[g];
        e.lsu_rdata = m_rd[g];
        if (!m_busy[g]) begin
          any = stim[g].ifu_v || stim[g].lsu_v;
          if (stim[g].ifu_v && stim[g].lsu_v) pick_lsu = prio_of[g] ? 1'b1 : !m_last[g];
          else                                pick_lsu = stim[g].lsu_v;
          if (any) begin
            e.lsu_rdy  = pick_lsu;
            e.ifu_rdy  = !pick_lsu;
            m_busy[g]  = 1'b1;
            m_acc[g]   = cyc;
            m_lsu[g]   = pick_lsu;
            m_last[g]  = pick_lsu;
            m_we[g]    = pick_lsu && stim[g].lsu_we;
            m_addr[g]  = pick_lsu ? stim[g].lsu_addr  : stim[g].ifu_addr;
            m_wdata[g] = pick_lsu ? stim[g].lsu_wdata : 64'h0;
            m_mask[g]  = pick_lsu ? stim[g].lsu_wmask : 8'h0;
          end
        end else begin
          ph = cyc - m_acc[g];
          if (ph <= lat_of[g]) begin
            e.r_en  = !m_we[g];
            e.w_en  = m_we[g];
            e.addr  = m_addr[g];
            e.wdata = m_wdata[g];
            e.wmask = m_mask[g];
            if (ph == lat_of[g]) m_rd[g] = m_we[g] ? 64'h0 : memf(m_addr[g]);
          end else begin
            e.ifu_rv  = !m_lsu[g];
            e.lsu_rv  = m_lsu[g];
            m_busy[g] = 1'b0;
          end
        end
      end
      vectors++;
      if (obs[g] !== e) begin
        miscompares++;
        $display("FAIL model[%0d] cyc %0d: got %h, want %h", g, cyc, obs[g], e);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int g = 0; g < 3; g++) snap[g] = obs[g];
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_all(in_t s);
    for (int g = 0; g < 3; g++) stim[g] = s;
  endtask

  initial begin
    in_t         s;
    logic [63:0] tab [3];
    int          idx [3];
    tab[0] = 64'h0000_0000_0000_0100;
    tab[1] = 64'h0000_0000_0000_0208;
    tab[2] = 64'h0000_0000_0000_0310;

    // Reset with both requesters already asking.
    s = '0;
    s.ifu_v = 1'b1; s.ifu_addr = 64'h1000;
    s.lsu_v = 1'b1; s.lsu_addr = 64'h2000;
    set_all(s);
    rst_n = 1'b0;
    tick();
    chk64("rst_outs", {snap[0].ifu_rdy, snap[0].lsu_rdy, snap[1].ifu_rdy, snap[1].lsu_rdy,
                       snap[0].r_en, snap[0].w_en, snap[0].ifu_rv, snap[0].lsu_rv}, 64'h0);
    tick();
    rst_n = 1'b1;

    // Both valid continuously: fixed priority vs alternation.
    for (int k = 0; k < 12; k++) begin
      tick();
      chk1("prio_lsu_rdy", snap[0].lsu_rdy, (k % 4) == 0);
      chk1("prio_ifu_rdy", snap[0].ifu_rdy, 1'b0);
      chk1("rr_ifu_rdy", snap[1].ifu_rdy, (k % 8) == 0);
      chk1("rr_lsu_rdy", snap[1].lsu_rdy, (k % 8) == 4);
    end
    set_all('0);
    repeat (6) tick();

    // IFU read with a known DMEM word.
    s = '0; s.ifu_v = 1'b1; s.ifu_addr = 64'h8000_0000;
    set_all(s);
    tick();
    chk1("ifu_rd_rdy", snap[0].ifu_rdy, 1'b1);
    set_all('0);
    tick();
    chk1("ifu_rd_ren1", snap[0].r_en, 1'b1);
    chk64("ifu_rd_addr", snap[0].addr, 64'h8000_0000);
    tick();
    chk1("ifu_rd_ren2", snap[0].r_en, 1'b1);
    chk1("lat1_ifu_rv", snap[2].ifu_rv, 1'b1);
    tick();
    chk1("ifu_rd_rv", snap[0].ifu_rv, 1'b1);
    chk64("ifu_rd_data", snap[0].ifu_rdata, 64'h0000_0413_0000_0093);
    tick();

    // LSU full-mask write.
    s = '0; s.lsu_v = 1'b1; s.lsu_we = 1'b1; s.lsu_addr = 64'h8000_8ff0;
    s.lsu_wdata = 64'hdead_beef_cafe_f00d; s.lsu_wmask = 8'hFF;
    set_all(s);
    tick();
    chk1("wr_rdy", snap[0].lsu_rdy, 1'b1);
    set_all('0);
    tick();
    chk1("wr_wen1", snap[0].w_en, 1'b1);
    chk1("wr_ren1", snap[0].r_en, 1'b0);
    chk64("wr_addr", snap[0].addr, 64'h8000_8ff0);
    chk64("wr_wdata", snap[0].wdata, 64'hdead_beef_cafe_f00d);
    chk64("wr_wmask", {56'h0, snap[0].wmask}, 64'hFF);
    tick();
    chk1("wr_wen2", snap[0].w_en, 1'b1);
    tick();
    chk1("wr_rv", snap[0].lsu_rv, 1'b1);
    chk64("wr_rdata", snap[0].lsu_rdata, 64'h0);
    tick();

    // Reset lands in the first access cycle of an LSU read.
    s = '0; s.lsu_v = 1'b1; s.lsu_addr = 64'h8000_0100;
    set_all(s);
    tick();
    set_all('0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk1("abort_ren", snap[0].r_en, 1'b0);
    chk1("abort_rv2", snap[0].lsu_rv, 1'b0);
    tick();
    chk1("abort_rv3", snap[0].lsu_rv, 1'b0);
    s = '0; s.ifu_v = 1'b1; s.ifu_addr = 64'h8000_0000;
    set_all(s);
    tick();
    chk1("post_abort_rdy", snap[0].ifu_rdy, 1'b1);
    set_all('0);
    tick();
    tick();
    tick();
    chk1("post_abort_rv", snap[0].ifu_rv, 1'b1);
    chk64("post_abort_data", snap[0].ifu_rdata, 64'h0000_0413_0000_0093);
    repeat (3) tick();

    // Back-to-back LSU reads; the MEM_LAT=1 instance is pinned.
    for (int g = 0; g < 3; g++) idx[g] = 0;
    for (int k = 0; k < 10; k++) begin
      for (int g = 0; g < 3; g++) begin
        if (k > 0 && snap[g].lsu_rdy) idx[g]++;
        stim[g] = '0;
        stim[g].lsu_v    = idx[g] < 3;
        stim[g].lsu_addr = tab[(idx[g] < 3) ? idx[g] : 2];
      end
      tick();
      chk1("b2b_rdy", snap[2].lsu_rdy, (k == 0) || (k == 3) || (k == 6));
      chk1("b2b_rv", snap[2].lsu_rv, (k == 2) || (k == 5) || (k == 8));
      if (k == 2 || k == 5 || k == 8) chk64("b2b_data", snap[2].lsu_rdata, memf(tab[(k - 2) / 3]));
    end
    set_all('0);
    repeat (4) tick();

    // Randomized traffic with occasional resets; requests are held until accepted.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int g = 0; g < 3; g++) begin
        if (!stim[g].ifu_v || snap[g].ifu_rdy) begin
          stim[g].ifu_v    = ($urandom_range(0, 99) < 45);
          stim[g].ifu_addr = ($urandom_range(0, 7) == 0) ? 64'h8000_0000 : {32'h0, $urandom};
        end
        if (!stim[g].lsu_v || snap[g].lsu_rdy) begin
          stim[g].lsu_v     = ($urandom_range(0, 99) < 45);
          stim[g].lsu_we    = $urandom_range(0, 1) == 1;
          stim[g].lsu_addr  = {$urandom, $urandom};
          stim[g].lsu_wdata = {$urandom, $urandom};
          stim[g].lsu_wmask = 8'($urandom_range(0, 255));
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
